// File: rtl/digest_serializer.sv
// digest_serializer: sends a 512-bit SHA3-512 digest to the host as 16-bit words.
// Words go out MSB first. Each word advances on a rising edge of the asynchronous
// host acknowledge, after that edge has been synchronised into clk.
module digest_serializer #(
  parameter int DIGEST_W    = 512,
  parameter int WORD_W      = 16,
  parameter int NUM_WORDS   = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                go,
  input  logic                kill,
  input  logic [DIGEST_W-1:0] digest,
  input  logic                host_ack,
  output logic [WORD_W-1:0]   dout,
  output logic                valid,
  output logic                busy,
  output logic                done
);

  localparam int CNT_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    FINISH = 2'd2
  } stateT;

  stateT                  state;
  logic [DIGEST_W-1:0]    shiftReg;
  logic [CNT_W-1:0]       wordCount;
  logic [SYNC_STAGES-1:0] ackSync;
  logic                   ackPrev;
  logic                   syncLast;
  logic                   ackRise;

  // The last synchroniser stage is the clean, clk-domain copy of host_ack.
  assign syncLast = ackSync[SYNC_STAGES-1];
  // One-cycle strobe on a low-to-high transition of the synchronised acknowledge.
  assign ackRise  = syncLast & ~ackPrev;

  // Synchronise host_ack and keep its previous value; this runs in every state so
  // a level held high across a go never looks like a fresh edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ackSync <= {SYNC_STAGES{1'b0}};
      ackPrev <= 1'b0;
    end else begin
      ackSync <= {ackSync[SYNC_STAGES-2:0], host_ack};
      ackPrev <= syncLast;
    end
  end

  // Transfer state machine: load on go, advance one word per ack edge, pulse done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      shiftReg  <= {DIGEST_W{1'b0}};
      wordCount <= {CNT_W{1'b0}};
      dout      <= {WORD_W{1'b0}};
      valid     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (kill) begin
      // Abort wins over go and over any pending ack edge; no done pulse.
      state     <= IDLE;
      shiftReg  <= {DIGEST_W{1'b0}};
      wordCount <= {CNT_W{1'b0}};
      dout      <= {WORD_W{1'b0}};
      valid     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (go) begin
            shiftReg  <= digest;
            dout      <= digest[DIGEST_W-1 -: WORD_W];
            wordCount <= {CNT_W{1'b0}};
            valid     <= 1'b1;
            busy      <= 1'b1;
            state     <= SEND;
          end else begin
            valid <= 1'b0;
            busy  <= 1'b0;
          end
        end

        SEND: begin
          valid <= 1'b1;
          busy  <= 1'b1;
          done  <= 1'b0;
          if (ackRise) begin
            if (wordCount != LAST_WORD) begin
              // The word after the current one sits just below the top slot.
              shiftReg  <= shiftReg << WORD_W;
              dout      <= shiftReg[DIGEST_W-WORD_W-1 -: WORD_W];
              wordCount <= wordCount + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
              // Last word acknowledged: clear the bus and flag completion.
              dout  <= {WORD_W{1'b0}};
              valid <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= FINISH;
            end
          end else begin
            state <= SEND;
          end
        end

        FINISH: begin
          // done was raised on entry; it lasts exactly this one cycle.
          done  <= 1'b0;
          valid <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state     <= IDLE;
          shiftReg  <= {DIGEST_W{1'b0}};
          wordCount <= {CNT_W{1'b0}};
          dout      <= {WORD_W{1'b0}};
          valid     <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule
